fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/common_pkg.sv | 14 +
 rtl/pipes_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 44 ++++
 rtl/fetch_queue.sv | 85 ++++++++
 tb/tb_fetch_queue.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// common: instruction-bus request/response types shared across the core
package common;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// pipes: pipeline payload types passed between front-end stages
package pipes;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of fetched {pc, instr} pairs
module fetch_fifo
    import pipes::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  fetch_entry_t                 wdata,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;

    // storage write; flushing only rewinds pointers, so the array itself needs no reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= wdata;
    end

    // pointers wrap naturally at DEPTH (power of two); flush overrides push/pop
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetcher feeding a small {pc, instr} queue
module fetch_queue
    import common::*;
    import pipes::*;
#(
    parameter int          DEPTH   = 4,
    parameter logic [63:0] PC_INIT = 64'h8000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output ibus_req_t                  ireq,
    input  ibus_resp_t                 iresp,
    input  logic                       redirect_valid,
    input  logic [63:0]                redirect_pc,
    output logic                       out_valid,
    output logic [63:0]                out_pc,
    output logic [31:0]                out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

    state_e        state_q, state_d;
    logic [63:0]   fpc_q, fpc_d, drop_q, drop_d;
    logic          push, pop;
    logic [CW-1:0] post_cnt;
    fetch_entry_t  head;

    assign push     = state_q == REQ && iresp.data_ok && !redirect_valid;
    assign pop      = out_valid && out_ready && !redirect_valid;
    assign post_cnt = count + CW'(push) - CW'(pop);

    assign ireq.valid = state_q != IDLE;
    assign ireq.addr  = state_q == DROP ? drop_q : fpc_q;
    assign out_valid  = count != '0;
    assign out_pc     = head.pc;
    assign out_instr  = head.instr;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ('{pc: fpc_q, instr: iresp.data}),
        .pop   (pop),
        .flush (redirect_valid),
        .head  (head),
        .count (count)
    );

    // next fetch state: a redirect always retargets fpc; an in-flight request is drained in DROP
    always_comb begin
        state_d = state_q;
        fpc_d   = redirect_valid ? redirect_pc : fpc_q;
        drop_d  = state_q == REQ ? fpc_q : drop_q;
        case (state_q)
            IDLE:    state_d = !redirect_valid && count < FULL ? REQ : IDLE;
            REQ: begin
                if (redirect_valid) state_d = iresp.data_ok ? IDLE : DROP;
                else if (iresp.data_ok) begin
                    fpc_d   = fpc_q + 64'd4;
                    state_d = post_cnt < FULL ? REQ : IDLE;
                end
            end
            DROP:    state_d = iresp.data_ok ? IDLE : DROP;
            default: state_d = IDLE;
        endcase
    end

    // fetch state registers; reset dominates redirects and bus responses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            fpc_q   <= PC_INIT;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios checked against a queue-based reference model
module tb_fetch_queue;
    import common::*;

    localparam int          DEPTH   = 4;
    localparam logic [63:0] PC_INIT = 64'h8000_0000;

    logic        clk;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  count;

    fetch_queue #(.DEPTH(DEPTH), .PC_INIT(PC_INIT)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready),
        .count          (count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [63:0] a);
        return a[31:0] + 32'h1000_0000;
    endfunction

    // reference model: the queue contents plus a record of the one outstanding request
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_fpc, m_addr;
    bit          m_busy, m_drop, m_on;
    bit          m_acc, m_pop;
    int          m_pre;

    initial begin
        m_on = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                mq.delete();
                m_fpc  = PC_INIT;
                m_addr = PC_INIT;
                m_busy = 0;
                m_drop = 0;
                m_on   = 1;
            end else if (m_on) begin
                m_acc = m_busy && iresp.data_ok;
                m_pop = mq.size() != 0 && out_ready && !redirect_valid;
                m_pre = mq.size();
                if (redirect_valid) begin
                    mq.delete();
                    m_fpc = redirect_pc;
                    if (m_busy && !m_acc) m_drop = 1;
                    else begin
                        m_busy = 0;
                        m_drop = 0;
                    end
                end else begin
                    if (m_pop) void'(mq.pop_front());
                    if (m_acc) begin
                        if (!m_drop) begin
                            mq.push_back('{m_addr, iresp.data});
                            m_fpc = m_fpc + 64'd4;
                        end
                        m_busy = !m_drop && mq.size() < DEPTH;
                        m_drop = 0;
                        m_addr = m_fpc;
                    end else if (!m_busy) begin
                        m_busy = m_pre < DEPTH;
                        m_addr = m_fpc;
                    end
                end
            end
        end
    end

    // every cycle, mid-period: DUT outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (m_on) begin
                chk("ireq_valid", ireq.valid, m_busy);
                if (m_busy) chk("ireq_addr", ireq.addr, m_addr);
                chk("count", count, mq.size());
                chk("out_valid", out_valid, mq.size() != 0);
                if (mq.size() != 0) begin
                    chk("out_pc", out_pc, mq[0].pc);
                    chk("out_instr", out_instr, mq[0].instr);
                end
            end
        end
    end

    // memory responder state and bench bookkeeping
    int          wait_n = 0;
    int          lat = 1;
    int          taken_n = 0;
    bit          resp_en = 1;
    logic [63:0] popped[$];
    logic [31:0] popped_i[$];

    task automatic cycle();
        logic taken, was_rst;
        taken   = iresp.data_ok && ireq.valid;
        was_rst = reset;
        if (out_valid && out_ready && !redirect_valid && !reset) begin
            popped.push_back(out_pc);
            popped_i.push_back(out_instr);
        end
        @(posedge clk);
        #1;
        if (taken && !was_rst) taken_n++;
        if (was_rst || taken) wait_n = 0;
        iresp.data_ok = ireq.valid && resp_en && wait_n >= lat;
        iresp.data    = mem(ireq.addr);
        if (ireq.valid && !iresp.data_ok) wait_n++;
    endtask

    task automatic do_reset();
        reset = 1;
        redirect_valid = 0;
        out_ready = 0;
        resp_en = 1;
        cycle();
        cycle();
        reset = 0;
    endtask

    logic [7:0] pat;

    initial begin
        reset = 1;
        redirect_valid = 0;
        redirect_pc = '0;
        out_ready = 0;
        iresp = '0;

        // reset state and first request timing
        do_reset();
        chk("rst_valid", ireq.valid, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        cycle();
        chk("first_req_valid", ireq.valid, 1'b1);
        chk("first_req_addr", ireq.addr, 64'h8000_0000);

        // streaming with one-cycle memory latency
        do_reset();
        lat = 1;
        out_ready = 1;
        popped.delete();
        popped_i.delete();
        for (int i = 0; i < 40 && popped.size() < 3; i++) cycle();
        chk("stream_pops", popped.size(), 3);
        if (popped.size() >= 3) begin
            chk("stream_pc0", popped[0], 64'h8000_0000);
            chk("stream_pc1", popped[1], 64'h8000_0004);
            chk("stream_pc2", popped[2], 64'h8000_0008);
            chk("stream_in0", popped_i[0], 32'h9000_0000);
            chk("stream_in2", popped_i[2], 32'h9000_0008);
        end

        // fill to DEPTH with consumer stalled, then release one entry
        do_reset();
        lat = 1;
        taken_n = 0;
        for (int i = 0; i < 20; i++) cycle();
        chk("full_count", count, 3'd4);
        chk("full_valid", ireq.valid, 1'b0);
        chk("full_reqs", taken_n, 4);
        popped.delete();
        out_ready = 1;
        cycle();
        out_ready = 0;
        chk("drain_count", count, 3'd3);
        chk("drain_pc", popped.size() > 0 ? popped[0] : 64'hx, 64'h8000_0000);
        cycle();
        chk("resume_valid", ireq.valid, 1'b1);
        chk("resume_addr", ireq.addr, 64'h8000_0010);

        // redirect while a slow response is outstanding
        do_reset();
        lat = 3;
        cycle();
        chk("drop_pre_addr", ireq.addr, 64'h8000_0000);
        redirect_valid = 1;
        redirect_pc = 64'h8000_0100;
        cycle();
        redirect_valid = 0;
        chk("drop_valid", ireq.valid, 1'b1);
        chk("drop_addr", ireq.addr, 64'h8000_0000);
        for (int i = 0; i < 30 && !out_valid; i++) cycle();
        chk("drop_out_valid", out_valid, 1'b1);
        chk("drop_out_pc", out_pc, 64'h8000_0100);
        chk("drop_out_instr", out_instr, 32'h9000_0100);

        // redirect coincident with data_ok and a ready consumer
        do_reset();
        lat = 1;
        for (int i = 0; i < 30 && !(count == 3'd2 && iresp.data_ok); i++) cycle();
        chk("coinc_pre_count", count, 3'd2);
        redirect_valid = 1;
        redirect_pc = 64'h8000_0200;
        out_ready = 1;
        cycle();
        redirect_valid = 0;
        out_ready = 0;
        chk("coinc_count", count, 3'd0);
        chk("coinc_valid", ireq.valid, 1'b0);
        cycle();
        chk("coinc_req_addr", ireq.addr, 64'h8000_0200);

        // simultaneous push and pop at count 2
        do_reset();
        lat = 1;
        for (int i = 0; i < 30 && !(count == 3'd2 && iresp.data_ok); i++) cycle();
        out_ready = 1;
        cycle();
        out_ready = 0;
        chk("pp_count", count, 3'd2);
        chk("pp_head", out_pc, 64'h8000_0004);
        resp_en = 0;
        popped.delete();
        out_ready = 1;
        cycle();
        cycle();
        out_ready = 0;
        resp_en = 1;
        chk("pp_pops", popped.size(), 2);
        if (popped.size() == 2) chk("pp_tail", popped[1], 64'h8000_0008);

        // reset taken while draining a stale response
        do_reset();
        lat = 5;
        cycle();
        redirect_valid = 1;
        redirect_pc = 64'h8000_0300;
        cycle();
        redirect_valid = 0;
        chk("rd_drop_addr", ireq.addr, 64'h8000_0000);
        reset = 1;
        cycle();
        chk("rd_valid", ireq.valid, 1'b0);
        chk("rd_count", count, 3'd0);
        reset = 0;
        cycle();
        chk("rd_req_addr", ireq.addr, 64'h8000_0000);

        // mixed traffic for pointer wrap and a mid-stream redirect, model-checked
        do_reset();
        pat = 8'b1011_0010;
        lat = 0;
        for (int i = 0; i < 80; i++) begin
            out_ready = pat[i % 8];
            redirect_valid = (i == 37);
            redirect_pc = 64'h8000_1000;
            if (i == 50) lat = 2;
            cycle();
        end
        redirect_valid = 0;
        out_ready = 0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
